// File: rtl/sw_event_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : sw_event_decoder
//  Purpose  : Turns a debounced switch level into single-cycle gesture events
//             (press, release, click, long press, auto-repeat) plus a HELD
//             level. One instance per switch, directly after the debouncer.
//  Revision : 1.0 - initial release
// ============================================================================
module sw_event_decoder #(
  parameter int LONG_CYCLES   = 12_500_000,
  parameter int REPEAT_CYCLES = 2_500_000,
  parameter int CNT_W         = 24
) (
  input  logic CLK,
  input  logic RST,
  input  logic SW_DB,
  output logic PRESS,
  output logic RELEASE,
  output logic CLICK,
  output logic LONG,
  output logic REPEAT,
  output logic HELD
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_long   = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] c_repeat = CNT_W'(REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_sw_q;
  logic             w_press;
  logic             w_release;
  logic             w_click;
  logic             w_long;
  logic             w_repeat;

  // State, hold counter, sampled switch and all event outputs are registered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sw_q  <= 1'b0;
      PRESS   <= 1'b0;
      RELEASE <= 1'b0;
      CLICK   <= 1'b0;
      LONG    <= 1'b0;
      REPEAT  <= 1'b0;
      HELD    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sw_q  <= SW_DB;
      PRESS   <= w_press;
      RELEASE <= w_release;
      CLICK   <= w_click;
      LONG    <= w_long;
      REPEAT  <= w_repeat;
      HELD    <= (w_state_nxt != ST_IDLE);
    end
  end

  // Next-state / event decode; a sampled release always beats a terminal count.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_press     = 1'b0;
    w_release   = 1'b0;
    w_click     = 1'b0;
    w_long      = 1'b0;
    w_repeat    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (SW_DB) begin
          w_state_nxt = ST_PRESSED;
          w_cnt_nxt   = c_one;
          w_press     = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!SW_DB) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_release   = 1'b1;
          w_click     = 1'b1;
        end else if (r_cnt == c_long) begin
          w_state_nxt = ST_HELD;
          w_cnt_nxt   = c_one;
          w_long      = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + c_one;
        end
      end
      ST_HELD: begin
        if (!SW_DB) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_release   = 1'b1;
        end else if (r_cnt == c_repeat) begin
          w_cnt_nxt   = c_one;
          w_repeat    = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + c_one;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // The FSM leaves IDLE exactly when it samples a 1 and returns exactly when it
  // samples a 0, so HELD must always mirror the previously sampled switch.
  a_held_matches_sw: assert property (@(posedge CLK) disable iff (RST) HELD == r_sw_q);
  a_single_event: assert property (@(posedge CLK) disable iff (RST) $onehot0({PRESS, LONG, REPEAT}));

endmodule
`default_nettype wire

// File: tb/tb_sw_event_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sw_event_decoder
//  Purpose  : Self-checking bench for sw_event_decoder (LONG=8, REPEAT=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sw_event_decoder;

  localparam int c_long = 8;
  localparam int c_rep  = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic SW_DB = 1'b0;
  logic PRESS, RELEASE, CLICK, LONG, REPEAT, HELD;

  int  n_checks = 0;
  int  n_pass   = 0;
  bit  chk_en   = 1'b0;

  // Reference model state: whether a press is in progress and edges since E0.
  bit         m_active = 1'b0;
  int         m_k      = 0;
  logic [5:0] e_vec    = 6'b0;  // {PRESS,RELEASE,CLICK,LONG,REPEAT,HELD}

  sw_event_decoder #(
    .LONG_CYCLES  (c_long),
    .REPEAT_CYCLES(c_rep),
    .CNT_W        (8)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .SW_DB  (SW_DB),
    .PRESS  (PRESS),
    .RELEASE(RELEASE),
    .CLICK  (CLICK),
    .LONG   (LONG),
    .REPEAT (REPEAT),
    .HELD   (HELD)
  );

  always #5 CLK = ~CLK;

  function automatic logic [5:0] dut_vec();
    return {PRESS, RELEASE, CLICK, LONG, REPEAT, HELD};
  endfunction

  task automatic check(input string nm, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (P R C L Rp H) at %0t", nm, act, exp, $time);
  endtask

  // Timing-rule model: events are derived from the edge count since E0.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_active = 1'b0;
      m_k      = 0;
      e_vec    = 6'b0;
    end else begin
      e_vec = 6'b0;
      if (!m_active) begin
        if (SW_DB) begin
          m_active = 1'b1;
          m_k      = 0;
          e_vec[5] = 1'b1;
        end
      end else begin
        m_k++;
        if (!SW_DB) begin
          m_active = 1'b0;
          e_vec[4] = 1'b1;
          e_vec[3] = (m_k <= c_long);
        end else begin
          e_vec[2] = (m_k == c_long);
          e_vec[1] = (m_k > c_long) && (((m_k - c_long) % c_rep) == 0);
        end
      end
      e_vec[0] = m_active;
    end
  end

  // Every cycle: DUT outputs against the model.
  always @(posedge CLK) begin
    #2;
    if (chk_en) check("model", dut_vec(), e_vec);
  end

  // Drive SW_DB for one edge; returns shortly after that edge.
  task automatic edge_with(input logic v);
    @(negedge CLK);
    SW_DB = v;
    @(posedge CLK);
    #3;
  endtask

  task automatic idle_gap();
    edge_with(1'b0);
    edge_with(1'b0);
  endtask

  logic v;
  int   len;

  initial begin
    // 1. Reset behaviour.
    #2 RST = 1'b1;
    #1 check("reset_async", dut_vec(), 6'b000000);
    chk_en = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      edge_with(1'b0);
      check("idle_quiet", dut_vec(), 6'b000000);
    end

    // 2. Short press: five 1s then a 0.
    for (int k = 0; k < 5; k++) begin
      edge_with(1'b1);
      check("short_hold", dut_vec(), (k == 0) ? 6'b100001 : 6'b000001);
    end
    edge_with(1'b0);
    check("short_release", dut_vec(), 6'b011000);
    idle_gap();

    // 3. Long hold: 1s at E0..E0+19, 0 at E0+20.
    for (int k = 0; k < 20; k++) begin
      edge_with(1'b1);
      check("long_hold", dut_vec(),
            (k == 0)            ? 6'b100001 :
            (k == 8)            ? 6'b000101 :
            (k == 12 || k == 16) ? 6'b000011 : 6'b000001);
    end
    edge_with(1'b0);
    check("long_release", dut_vec(), 6'b010000);
    idle_gap();

    // 4a. Release exactly at E0+8: click, no LONG.
    for (int k = 0; k < 8; k++) begin
      edge_with(1'b1);
      check("bound8_hold", dut_vec(), (k == 0) ? 6'b100001 : 6'b000001);
    end
    edge_with(1'b0);
    check("bound8_release", dut_vec(), 6'b011000);
    idle_gap();

    // 4b. Release at E0+9: LONG then release without click.
    for (int k = 0; k < 9; k++) begin
      edge_with(1'b1);
      check("bound9_hold", dut_vec(), (k == 0) ? 6'b100001 : (k == 8) ? 6'b000101 : 6'b000001);
    end
    edge_with(1'b0);
    check("bound9_release", dut_vec(), 6'b010000);
    idle_gap();

    // 5. Single-edge glitch followed by an immediate new press.
    edge_with(1'b1);
    check("glitch_press", dut_vec(), 6'b100001);
    edge_with(1'b0);
    check("glitch_release", dut_vec(), 6'b011000);
    edge_with(1'b1);
    check("repress", dut_vec(), 6'b100001);
    edge_with(1'b0);
    check("repress_release", dut_vec(), 6'b011000);
    idle_gap();

    // 6. Reset in the middle of a hold with the switch still down.
    for (int k = 0; k < 11; k++) edge_with(1'b1);
    #1 RST = 1'b1;
    #1 check("reset_midhold", dut_vec(), 6'b000000);
    repeat (3) @(posedge CLK);
    #3 check("reset_held", dut_vec(), 6'b000000);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #3 check("post_reset_press", dut_vec(), 6'b100001);
    for (int k = 1; k <= 8; k++) begin
      edge_with(1'b1);
      check("post_reset_hold", dut_vec(), (k == 8) ? 6'b000101 : 6'b000001);
    end
    idle_gap();

    // Randomised runs of held/released levels with occasional async resets.
    v = 1'b0;
    repeat (300) begin
      v   = ~v;
      len = $urandom_range(1, 26);
      for (int i = 0; i < len; i++) begin
        @(negedge CLK);
        SW_DB = v;
        if ($urandom_range(0, 199) == 0) begin
          #3 RST = 1'b1;
          repeat (2) @(negedge CLK);
          RST = 1'b0;
        end
      end
    end
    @(negedge CLK);
    SW_DB = 1'b0;
    repeat (3) @(negedge CLK);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sw_event_decoder.md
# sw_event_decoder

Converts the clean level produced by the switch debouncer into single-cycle gesture events: press, release, short click, long press and auto-repeat while held. It sits directly downstream of the debounce stage, one instance per switch. Its pulses drive game and menu logic directly, so no consumer needs its own edge detection or hold timers.

## Interface
Parameters:
- LONG_CYCLES, default 12_500_000: cycles from press to the LONG event (0.5 s at 25 MHz). Must be ≥ 2.
- REPEAT_CYCLES, default 2_500_000: period of REPEAT pulses after LONG. Must be ≥ 1.
- CNT_W, default 24: hold-counter width. LONG_CYCLES and REPEAT_CYCLES must each be < 2^CNT_W.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- SW_DB  in  1  debounced switch level, synchronous to CLK; 1 = pressed.
- PRESS  out  1  one-cycle pulse on press.
- RELEASE  out  1  one-cycle pulse on release.
- CLICK  out  1  one-cycle pulse on a release that happens before LONG fires.
- LONG  out  1  one-cycle pulse when the hold reaches LONG_CYCLES.
- REPEAT  out  1  one-cycle pulse every REPEAT_CYCLES after LONG while the switch is still held.
- HELD  out  1  level, 1 while the FSM is not IDLE.

## Operation
- All outputs are registered.
- Reset state: FSM = IDLE, sampled-switch register sw_q = 0, counter = 0, all outputs 0.
- FSM states:
  - IDLE: when SW_DB = 1 is sampled, go to PRESSED, pulse PRESS, counter ← 1.
  - PRESSED: when SW_DB = 0 is sampled, go to IDLE and pulse RELEASE and CLICK. Otherwise:
    - if counter = LONG_CYCLES, go to HELD, pulse LONG, counter ← 1;
    - else counter ← counter + 1.
  - HELD: when SW_DB = 0 is sampled, go to IDLE and pulse RELEASE only (no CLICK). Otherwise:
    - if counter = REPEAT_CYCLES, pulse REPEAT, counter ← 1;
    - else counter ← counter + 1.
- A sampled release always takes priority. If release and a LONG or REPEAT terminal count fall on the same edge, only RELEASE (plus CLICK when in PRESSED) fires; LONG/REPEAT is suppressed.
- The counter never exceeds max(LONG_CYCLES, REPEAT_CYCLES), so it cannot wrap.
- At most one of PRESS, LONG, REPEAT is high in any cycle. RELEASE and CLICK are only ever high together or RELEASE alone.
- The FSM performs edge detection itself (IDLE sees 1, PRESSED/HELD see 0). sw_q is kept for HELD-consistency checks only; HELD equals the registered FSM ≠ IDLE.
- Reset mid-operation: the block returns to IDLE immediately. If SW_DB is still 1 after RST deasserts, the first edge generates a fresh PRESS. This is intended: a held switch at power-up counts as a press.

## Timing
- Let E0 be the first rising edge at which IDLE samples SW_DB = 1.
- PRESS and HELD go high in the cycle following E0.
- LONG is high in the cycle following edge E0 + LONG_CYCLES, provided SW_DB = 1 at every edge E0 … E0 + LONG_CYCLES.
- The n-th REPEAT (n ≥ 1) is high in the cycle following edge E0 + LONG_CYCLES + n·REPEAT_CYCLES.
- Let Er be the first edge sampling SW_DB = 0 after E0. RELEASE is high in the cycle following Er. CLICK accompanies it if Er ≤ E0 + LONG_CYCLES. HELD falls in that same cycle.
- A new press can be accepted at Er + 1 (IDLE after one cycle). The minimum press-to-press spacing is 2 cycles.
- Latency from input change to event output is exactly 1 edge; there is no extra synchronisation, because SW_DB is already synchronous.

## Test plan
Use LONG_CYCLES = 8, REPEAT_CYCLES = 4.
1. Reset: assert RST asynchronously mid-cycle → all outputs 0 immediately. Hold SW_DB = 0 for 10 cycles after release → no pulses.
2. Short press: SW_DB = 1 sampled at edges E0 … E0+4, 0 at E0+5 → PRESS after E0; RELEASE and CLICK after E0+5; no LONG; HELD high for 5 cycles.
3. Long hold: SW_DB = 1 from E0 through E0+19, 0 at E0+20 →
   - PRESS after E0, LONG after E0+8, REPEAT after E0+12 and E0+16;
   - after E0+20: RELEASE only; the REPEAT due at E0+20 is suppressed; no CLICK.
4. Boundary: release sampled exactly at E0+8 → RELEASE and CLICK after E0+8, LONG never asserted. Release at E0+9 → LONG after E0+8, then RELEASE without CLICK after E0+9.
5. Glitch: SW_DB = 1 for a single edge E0 → PRESS after E0, RELEASE and CLICK after E0+1. A new 1 at E0+2 → new PRESS after E0+2.
6. Reset mid-hold: assert RST at E0+10 with SW_DB = 1 and deassert 3 cycles later → outputs 0 during reset; PRESS after the first edge following deassert; LONG 8 edges after that.
